sram_arbiter: RTL and testbench
===============================

// Module: sram_arbiter
// PURPOSE
//  Shares one XSPRAM_1024X32_M8P-style SRAM macro between two word-addressed requesters.
//  - Port 0: CPU native memory bus. Port 1: DMA/debug bus.
//  - Both ports use valid/ready handshakes.
//  - Arbitrates between ports and sequences the macro's active-low CEn/WEn/OEn.
//  - The macro has no byte mask, so partial-byte writes are done as read-modify-write.
//  - Sits between the bus interconnect and the SRAM macro instance.
// PARAMETERS
//  ADDR_W  10  word-address width; 2**ADDR_W words
//  DATA_W  32  data width; must be 32 (4 byte lanes)
// PORTS
//  clk         in   1       single clock; also drives sram_clk
//  reset       in   1       synchronous, active-high
//  pN_valid    in   1       N=0,1: request valid; held until pN_ready
//  pN_addr     in   ADDR_W  word address; held with valid
//  pN_wdata    in   32      write data; held with valid
//  pN_wstrb    in   4       byte enables; 0 = read
//  pN_ready    out  1       one-cycle completion pulse
//  pN_rdata    out  32      read data; valid while pN_ready is high
//  sram_clk    out  1       = clk
//  sram_cen    out  1       macro enable, active low
//  sram_wen    out  1       macro write enable, active low
//  sram_oen    out  1       macro output enable, active low
//  sram_a      out  ADDR_W  macro address
//  sram_d      out  32      macro write data
//  sram_q      in   32      macro registered read data
// BEHAVIOUR
//  Reset and FSM
//  - Clock is clk. Reset is synchronous, active-high.
//  - Reset values: state=IDLE, pN_ready=0, pN_rdata=0, sram_cen/wen/oen=1, last_grant=1.
//  - FSM states: IDLE, RD, CAP, WR.
//  - SRAM controls are decoded combinationally from state; sram_cen is forced to 1 whenever reset=1.
//  IDLE
//  - If any valid: pick a winner, latch grant/addr/wdata/wstrb.
//  - wstrb==4'hF goes to WR; any other wstrb (read or partial write) goes to RD.
//  RD
//  - Drives cen=0, oen=0, wen=1, a=addr. Goes to CAP.
//  CAP
//  - sram_q holds mem[addr].
//  - Read: pG_ready=1, pG_rdata=sram_q, then IDLE.
//  - Partial write: merge per lane (wstrb[i] ? wdata byte : sram_q byte) into the wdata register, then WR.
//  WR
//  - Drives cen=0, wen=0, oen=1, a=addr, d=wdata register. pG_ready=1. Then IDLE.
//  - The write commits at the edge leaving WR.
//  Latency (valid sampled in IDLE at cycle N)
//  - Full write: ready at N+1.
//  - Read: ready at N+2.
//  - Partial write: ready at N+3.
//  - One idle cycle between transactions; peak rates are 1 per 2, 3 or 4 cycles.
//  Ready/rdata rules
//  - Only the granted port sees ready. pN_rdata is held until its next read completes.
//  - Ready also pulses on writes, with rdata unchanged.
//  Arbitration
//  - Round-robin. On a tie, the port opposite last_grant wins; last_grant updates on each grant.
//  - First tie after reset goes to port 0.
//  - A non-granted valid waits and is never dropped.
//  - Max wait is one transaction (at most 4 cycles plus IDLE).
//  Boundary conditions
//  - Requester drops valid mid-transaction: the transaction still completes and ready still pulses.
//  - Reset during RD/CAP/WR: returns to IDLE next edge. cen=1 on the reset edge, so no write commits. No ready.
//  - Address wraps within ADDR_W bits. No out-of-range detection.
//  - Same-address requests from both ports serialize in grant order. The second port sees the first port's write.
// CONFIGURATION
//  SRAM_ARB_FIXED_PRIO_EN
//  - Defined: fixed priority, port 0 always wins a tie; last_grant is unused. Port 1 can starve.
//  - Undefined (default): round-robin as above.
//  - Port list and timing are identical either way.
// TESTING
//  1. Full write: p0 write a=0x005, d=0xDEADBEEF, strb=F; then p0 read 0x005.
//     -> write ready at N+1; read ready at N+2 with rdata=0xDEADBEEF.
//  2. Partial write: mem[0x3FF]=0x11223344; p1 write d=0xAABBCCDD, strb=4'b0101.
//     -> RD,CAP,WR; ready at N+3; read-back=0x11BB33DD.
//  3. Tie from reset: both valid every cycle.
//     -> grants p0,p1,p0,p1 (round-robin); no pN_ready overlap.
//     -> with SRAM_ARB_FIXED_PRIO_EN: p0 only while p0 valid.
//  4. Reset in WR: assert reset during a p0 full write to 0x010 (old value 0x0).
//     -> cen=1 at that edge; mem[0x010] stays 0; p0_ready never pulses; state IDLE.
//  5. Contention: p1 valid while p0 is mid partial write.
//     -> p1 waits exactly until the IDLE after p0 WR; its valid/addr are not lost.
//  6. Address wrap: read at a=0x3FF, then a=0x000.
//     -> correct data for each; sram_a never exceeds 0x3FF.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-port valid/ready arbiter sharing a single-port SRAM macro; partial writes use read-modify-write.
// Define SRAM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties); the default is round-robin.
module sram_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_valid,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic [3:0]        p0_wstrb,
  output logic              p0_ready,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_valid,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic [3:0]        p1_wstrb,
  output logic              p1_ready,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              sram_clk,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic              sram_oen,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_CAP  = 2'd2;
  localparam logic [1:0] S_WR   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              pick;
  logic              req_any;
  logic              rd_done;
  logic              done;

  assign req_any = p0_valid | p1_valid;

`ifdef SRAM_ARB_FIXED_PRIO_EN
  assign pick = ~p0_valid;
`else
  logic last_grant_q;

  // On a tie the port that did not win last time goes next.
  assign pick = (p0_valid && p1_valid) ? ~last_grant_q : ~p0_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else if (state_q == S_IDLE && req_any) begin
      last_grant_q <= pick;
    end
  end
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          grant_d = pick;
          addr_d  = pick ? p1_addr  : p0_addr;
          wdata_d = pick ? p1_wdata : p0_wdata;
          wstrb_d = pick ? p1_wstrb : p0_wstrb;
          state_d = ((pick ? p1_wstrb : p0_wstrb) == 4'hF) ? S_WR : S_RD;
        end
      end
      S_RD: state_d = S_CAP;
      S_CAP: begin
        if (wstrb_q == 4'h0) begin
          state_d = S_IDLE;
        end else begin
          for (int i = 0; i < 4; i++) begin
            wdata_d[8*i +: 8] = wstrb_q[i] ? wdata_q[8*i +: 8] : sram_q[8*i +: 8];
          end
          state_d = S_WR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      if (rd_done && !grant_q) rdata0_q <= sram_q;
      if (rd_done &&  grant_q) rdata1_q <= sram_q;
    end
  end

  // NOTE: the request latches need no reset; nothing observes them until IDLE has reloaded them.
  always_ff @(posedge clk) begin
    grant_q <= grant_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    wstrb_q <= wstrb_d;
  end

  assign rd_done = (state_q == S_CAP) && (wstrb_q == 4'h0);
  assign done    = !reset && ((state_q == S_WR) || rd_done);

  assign p0_ready = done && !grant_q;
  assign p1_ready = done &&  grant_q;
  assign p0_rdata = (p0_ready && rd_done) ? sram_q : rdata0_q;
  assign p1_rdata = (p1_ready && rd_done) ? sram_q : rdata1_q;

  // The macro only sees an enable in RD and WR, and never while reset is held.
  assign sram_clk = clk;
  assign sram_cen = reset || !((state_q == S_RD) || (state_q == S_WR));
  assign sram_wen = (state_q != S_WR);
  assign sram_oen = !((state_q == S_RD) || (state_q == S_CAP));
  assign sram_a   = addr_q;
  assign sram_d   = wdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: transaction-level reference model, directed cases and random traffic.
module tb_sram_arbiter;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          valid [2];
  logic [AW-1:0] addr  [2];
  logic [31:0]   wdata [2];
  logic [3:0]    wstrb [2];
  logic          ready0, ready1;
  logic [31:0]   rdata0, rdata1;
  logic          sram_clk, sram_cen, sram_wen, sram_oen;
  logic [AW-1:0] sram_a;
  logic [31:0]   sram_d;
  logic [31:0]   sram_q;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .p0_valid(valid[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]), .p0_wstrb(wstrb[0]),
    .p0_ready(ready0), .p0_rdata(rdata0),
    .p1_valid(valid[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]), .p1_wstrb(wstrb[1]),
    .p1_ready(ready1), .p1_rdata(rdata1),
    .sram_clk(sram_clk), .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_oen(sram_oen),
    .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q)
  );

  always #5 clk = ~clk;

  // SRAM macro: registered read, write when enabled with WEn low.
  logic [31:0] sram_mem [1024];
  always @(posedge sram_clk) begin
    if (!sram_cen) begin
      if (!sram_wen) sram_mem[sram_a] <= sram_d;
      else           sram_q <= sram_mem[sram_a];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] strb);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return r;
  endfunction

  // Reference model: one outstanding transaction, ready arrives 'lat' cycles after the grant edge.
  logic [31:0]   ref_mem [1024];
  logic [31:0]   held [2];
  bit            busy = 1'b0;
  bit            last = 1'b1;
  bit            m_port;
  int            age, lat;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_data;
  logic [3:0]    m_strb;
  int            order_q[$];

  always @(negedge clk) begin
    bit rdy;
    logic [31:0] exp_rd [2];
    rdy = busy && !reset && (age == lat);
    for (int p = 0; p < 2; p++)
      exp_rd[p] = (rdy && m_port == p[0] && m_strb == 4'h0) ? ref_mem[m_addr] : held[p];
    if (chk_en) begin
      check("p0_ready", 32'(ready0), 32'(rdy && !m_port));
      check("p1_ready", 32'(ready1), 32'(rdy && m_port));
      check("p0_rdata", rdata0, exp_rd[0]);
      check("p1_rdata", rdata1, exp_rd[1]);
      check("ready_overlap", 32'(ready0 && ready1), 32'd0);
      if (!busy || reset) check("cen_idle", 32'(sram_cen), 32'd1);
      if (busy && !reset && age == 1 && m_strb != 4'hF) begin
        check("rd_cen", 32'(sram_cen), 32'd0);
        check("rd_wen", 32'(sram_wen), 32'd1);
        check("rd_oen", 32'(sram_oen), 32'd0);
        check("rd_addr", 32'(sram_a), 32'(m_addr));
      end
      if (rdy && m_strb != 4'h0) begin
        check("wr_cen", 32'(sram_cen), 32'd0);
        check("wr_wen", 32'(sram_wen), 32'd0);
        check("wr_oen", 32'(sram_oen), 32'd1);
        check("wr_addr", 32'(sram_a), 32'(m_addr));
        check("wr_data", sram_d, merge(ref_mem[m_addr], m_data, m_strb));
      end
    end
    if (rdy) order_q.push_back(int'(m_port));
    // Advance to the state after the coming clock edge.
    if (reset) begin
      busy = 1'b0;
      last = 1'b1;
      held[0] = '0;
      held[1] = '0;
    end else if (busy) begin
      if (age == lat) begin
        if (m_strb == 4'h0) held[m_port] = ref_mem[m_addr];
        else                ref_mem[m_addr] = merge(ref_mem[m_addr], m_data, m_strb);
        busy = 1'b0;
      end else begin
        age++;
      end
    end else if (valid[0] || valid[1]) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
      m_port = !valid[0];
`else
      m_port = (valid[0] && valid[1]) ? !last : !valid[0];
`endif
      last   = m_port;
      busy   = 1'b1;
      age    = 1;
      m_addr = addr[m_port];
      m_data = wdata[m_port];
      m_strb = wstrb[m_port];
      lat    = (m_strb == 4'hF) ? 1 : (m_strb == 4'h0) ? 2 : 3;
    end
  end

  // Starts and ends 1 time unit after a rising edge; n counts falling edges up to and including ready.
  task automatic req(input int p, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                     input bit drop, output int n, output logic [31:0] rd);
    bit got = 1'b0;
    valid[p] = 1'b1;
    addr[p]  = a;
    wdata[p] = d;
    wstrb[p] = s;
    n  = 0;
    rd = 'x;
    while (n < 40 && !got) begin
      @(negedge clk);
      n++;
      if ((p == 0) ? ready0 : ready1) begin
        got = 1'b1;
        rd  = (p == 0) ? rdata0 : rdata1;
      end else if (drop && n == 1) begin
        @(posedge clk);
        #1 valid[p] = 1'b0;
      end
    end
    check($sformatf("p%0d_req_done", p), 32'(got), 32'd1);
    @(posedge clk);
    #1 valid[p] = 1'b0;
  endtask

  task automatic rand_traffic(input int p, input int count);
    int n, g;
    logic [31:0] rd;
    logic [AW-1:0] a;
    logic [3:0] s;
    for (int k = 0; k < count; k++) begin
      g = $urandom_range(0, 2);
      if (g > 0) begin
        repeat (g) @(posedge clk);
        #1;
      end
      case ($urandom_range(0, 3))
        0:       a = 10'h3FF;
        1:       a = 10'h000;
        2:       a = AW'($urandom_range(0, 7));
        default: a = AW'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0:       s = 4'h0;
        1:       s = 4'hF;
        default: s = 4'($urandom);
      endcase
      req(p, a, $urandom, s, 1'b0, n, rd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n0, n1, bad;
    logic [31:0] rd, r0, r1;
    for (int i = 0; i < 1024; i++) begin
      sram_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    for (int p = 0; p < 2; p++) begin
      valid[p] = 1'b0;
      addr[p]  = '0;
      wdata[p] = '0;
      wstrb[p] = '0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;

    // Tie from reset: both ports keep a request pending.
    order_q.delete();
    fork
      begin req(0, 10'h001, 32'h0, 4'h0, 1'b0, n0, r0); req(0, 10'h002, 32'h0, 4'h0, 1'b0, n0, r0); end
      begin req(1, 10'h001, 32'h0, 4'h0, 1'b0, n1, r1); req(1, 10'h002, 32'h0, 4'h0, 1'b0, n1, r1); end
    join
    check("tie_count", 32'(order_q.size()), 32'd4);
`ifdef SRAM_ARB_FIXED_PRIO_EN
    check("tie_g0", 32'(order_q[0]), 32'd0);
    check("tie_g1", 32'(order_q[1]), 32'd0);
    check("tie_g2", 32'(order_q[2]), 32'd1);
    check("tie_g3", 32'(order_q[3]), 32'd1);
`else
    check("tie_g0", 32'(order_q[0]), 32'd0);
    check("tie_g1", 32'(order_q[1]), 32'd1);
    check("tie_g2", 32'(order_q[2]), 32'd0);
    check("tie_g3", 32'(order_q[3]), 32'd1);
`endif

    // Full write then read-back.
    req(0, 10'h005, 32'hDEADBEEF, 4'hF, 1'b0, n, rd);
    check("fw_latency", 32'(n), 32'd2);
    req(0, 10'h005, 32'h0, 4'h0, 1'b0, n, rd);
    check("rd_latency", 32'(n), 32'd3);
    check("rd_data", rd, 32'hDEADBEEF);

    // Partial write merges per byte lane.
    req(1, 10'h3FF, 32'h11223344, 4'hF, 1'b0, n, rd);
    req(1, 10'h3FF, 32'hAABBCCDD, 4'b0101, 1'b0, n, rd);
    check("pw_latency", 32'(n), 32'd4);
    req(1, 10'h3FF, 32'h0, 4'h0, 1'b0, n, rd);
    check("pw_readback", rd, 32'h11BB33DD);

    // Reset lands while a full write to 0x010 is in WR.
    valid[0] = 1'b1;
    addr[0]  = 10'h010;
    wdata[0] = 32'h12345678;
    wstrb[0] = 4'hF;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_wr_cen", 32'(sram_cen), 32'd1);
    check("rst_wr_ready", 32'(ready0), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    valid[0] = 1'b0;
    check("rst_wr_mem", sram_mem[16], 32'h0);
    req(0, 10'h010, 32'h0, 4'h0, 1'b0, n, rd);
    check("rst_idle_latency", 32'(n), 32'd3);
    check("rst_rd_data", rd, 32'h0);

    // Contention: p1 arrives while p0 is in a partial write to the same word.
    fork
      req(0, 10'h3FF, 32'h55667788, 4'b1000, 1'b0, n0, r0);
      begin @(posedge clk); #1; req(1, 10'h3FF, 32'h0, 4'h0, 1'b0, n1, r1); end
    join
    check("cont_p0_latency", 32'(n0), 32'd4);
    check("cont_p1_latency", 32'(n1), 32'd6);
    check("cont_p1_data", r1, 32'h55BB33DD);

    // Address wrap: top word then word 0.
    req(0, 10'h000, 32'h0BADF00D, 4'hF, 1'b0, n, rd);
    req(0, 10'h3FF, 32'h0, 4'h0, 1'b0, n, rd);
    check("wrap_top", rd, 32'h55BB33DD);
    req(0, 10'h000, 32'h0, 4'h0, 1'b0, n, rd);
    check("wrap_zero", rd, 32'h0BADF00D);

    // Requester drops valid right after the grant; the partial write still completes.
    req(0, 10'h020, 32'hFFFFFFFF, 4'b0001, 1'b1, n, rd);
    check("drop_latency", 32'(n), 32'd4);
    req(0, 10'h020, 32'h0, 4'h0, 1'b0, n, rd);
    check("drop_data", rd, 32'h000000FF);

    fork
      rand_traffic(0, 40);
      rand_traffic(1, 40);
    join

    repeat (2) @(posedge clk);
    bad = 0;
    for (int i = 0; i < 1024; i++) if (sram_mem[i] !== ref_mem[i]) bad++;
    check("mem_image", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
